// File: rtl/i2s_tx_fifo_if.sv
// Frame write port of the I2S transmitter: one stereo frame {left, right} per transfer.
// Handshake: a frame transfers on every in_clk edge where in_valid && in_ready;
// in_ready depends only on FIFO fullness, never on in_valid or the serial side.
interface i2s_tx_fifo_if #(
  parameter int SAMPLE_W = 16
);
  logic                  in_valid;
  logic [2*SAMPLE_W-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/i2s_tx_fifo.sv
// Single-clock I2S / left-justified transmitter with a stereo frame FIFO; bck, lrck
// and sout are all registered and derived from in_clk through a divider.
module i2s_tx_fifo #(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_W    = 32,
  parameter int DEPTH     = 4,
  parameter int BCK_DIV   = 4,
  parameter int REQ_LEVEL = 1
) (
  input  logic                         in_clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  i2s_tx_fifo_if.slave                 wr,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         audio_req,
  output logic                         underrun,
  output logic                         bck,
  output logic                         lrck,
  output logic                         sout
);

  localparam int FW         = 2 * SAMPLE_W;
  localparam int AW         = $clog2(DEPTH);
  localparam int LW         = $clog2(DEPTH + 1);
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int BW         = $clog2(FRAME_BITS);
  localparam int CW         = $clog2(BCK_DIV);

  logic [FW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_next;
  logic [FW-1:0]   frame_q;
  logic [FW-1:0]   frame_next;
  logic            mode_q;
  logic            mode_next;
  logic [LW-1:0]   level_next;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            rise_tick;
  logic            fall_tick;
  logic            frame_start;

  logic            right_slot;
  logic [BW-1:0]   slot_pos;
  logic [BW-1:0]   data_pos;
  logic [BW-1:0]   bit_idx;
  logic            in_sample;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] sample_sh;
  logic            bit_val;

  assign wr.in_ready = !full;

  always_comb begin
    full        = (level == LW'(DEPTH));
    empty       = (level == '0);
    push        = wr.in_valid && !full;
    rise_tick   = enable && (div_cnt == CW'(BCK_DIV/2 - 1));
    fall_tick   = enable && (div_cnt == CW'(BCK_DIV - 1));
    bit_next    = (bit_cnt == BW'(FRAME_BITS - 1)) ? '0 : bit_cnt + 1'b1;
    frame_start = fall_tick && (bit_next == '0);
    pop         = frame_start && !empty;
    level_next  = level + LW'(push) - LW'(pop);
    frame_next  = frame_q;
    mode_next   = mode_q;
    // An empty FIFO at frame start plays a silent frame.
    if (frame_start) begin
      frame_next = empty ? '0 : mem[rd_ptr];
      mode_next  = mode;
    end
  end

  // Bit for the position the counter is about to enter; I2S delays data by one bck.
  always_comb begin
    right_slot = (bit_next >= BW'(SLOT_W));
    slot_pos   = right_slot ? (bit_next - BW'(SLOT_W)) : bit_next;
    data_pos   = slot_pos - BW'(!mode_next);
    in_sample  = (slot_pos >= BW'(!mode_next)) && (data_pos < BW'(SAMPLE_W));
    bit_idx    = BW'(SAMPLE_W - 1) - data_pos;
    sample     = right_slot ? frame_next[SAMPLE_W-1:0] : frame_next[FW-1:SAMPLE_W];
    sample_sh  = sample >> bit_idx;
    bit_val    = in_sample && sample_sh[0];
  end

  always_ff @(posedge in_clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= wr.in_data;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      bck       <= 1'b0;
      lrck      <= 1'b0;
      sout      <= 1'b0;
      audio_req <= 1'b0;
      underrun  <= 1'b0;
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      frame_q   <= '0;
      mode_q    <= 1'b0;
    end else begin
      audio_req <= frame_start && (level_next <= LW'(REQ_LEVEL));
      underrun  <= frame_start && empty;
      level     <= level_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // Parking the bit counter on the last position makes the first fall a frame start.
      if (!enable) begin
        div_cnt <= '0;
        bit_cnt <= BW'(FRAME_BITS - 1);
        bck     <= 1'b0;
        lrck    <= 1'b0;
        sout    <= 1'b0;
      end else begin
        div_cnt <= fall_tick ? '0 : div_cnt + 1'b1;
        if (rise_tick) bck <= 1'b1;
        if (fall_tick) begin
          bck     <= 1'b0;
          bit_cnt <= bit_next;
          lrck    <= right_slot;
          sout    <= bit_val;
          frame_q <= frame_next;
          mode_q  <= mode_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Randomised bench for i2s_tx_fifo: a queue-based frame model predicts every output
// each cycle, and directed scenarios pin it with literal serial patterns.
module tb_i2s_tx_fifo;

  localparam int SAMPLE_W   = 16;
  localparam int SLOT_W     = 32;
  localparam int DEPTH      = 4;
  localparam int BCK_DIV    = 4;
  localparam int REQ_LEVEL  = 1;
  localparam int FW         = 2 * SAMPLE_W;
  localparam int LW         = $clog2(DEPTH + 1);
  localparam int FRAME_BITS = 2 * SLOT_W;
  localparam int FRAME_CYC  = FRAME_BITS * BCK_DIV;

  logic          in_clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          mode;
  logic [LW-1:0] level;
  logic          audio_req, underrun, bck, lrck, sout;

  i2s_tx_fifo_if #(.SAMPLE_W(SAMPLE_W)) wr ();

  i2s_tx_fifo #(
    .SAMPLE_W(SAMPLE_W), .SLOT_W(SLOT_W), .DEPTH(DEPTH),
    .BCK_DIV(BCK_DIV), .REQ_LEVEL(REQ_LEVEL)
  ) dut (
    .in_clk(in_clk), .reset(reset), .enable(enable), .mode(mode), .wr(wr),
    .level(level), .audio_req(audio_req), .underrun(underrun),
    .bck(bck), .lrck(lrck), .sout(sout)
  );

  // clock / reset block
  always #5 in_clk = ~in_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int und_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_frame;
  logic          m_mode;
  int            m_n;
  int            m_base;
  logic          e_bck, e_lrck, e_sout, e_req, e_und;
  bit            model_on = 0;

  function automatic logic model_bit(input logic [FW-1:0] f, input int pos, input logic md);
    int slot, p, d;
    logic [SAMPLE_W-1:0] s, sh;
    slot = pos / SLOT_W;
    p    = pos % SLOT_W;
    d    = md ? 0 : 1;
    s    = (slot == 1) ? f[SAMPLE_W-1:0] : f[FW-1:SAMPLE_W];
    if (p < d || (p - d) >= SAMPLE_W) return 1'b0;
    sh = s >> (SAMPLE_W - 1 - (p - d));
    return sh[0];
  endfunction

  always @(posedge in_clk) begin
    int nn, pos;
    bit fall, fs, acc;
    if (reset) begin
      exp_q.delete();
      m_n = 0; m_base = 0; m_frame = '0; m_mode = 1'b0;
      e_bck = 0; e_lrck = 0; e_sout = 0; e_req = 0; e_und = 0;
      model_on = 1;
    end else begin
      acc   = wr.in_valid && (exp_q.size() < DEPTH);
      e_req = 0;
      e_und = 0;
      if (enable) begin
        nn   = m_n + 1;
        fall = (nn % BCK_DIV) == 0;
        pos  = (m_base + nn / BCK_DIV) % FRAME_BITS;
        fs   = fall && (pos == 0);
        if (fs) begin
          if (exp_q.size() > 0) m_frame = exp_q.pop_front();
          else begin
            m_frame = '0;
            e_und   = 1;
          end
          m_mode = mode;
        end
        if (acc) exp_q.push_back(wr.in_data);
        if (fs) e_req = (exp_q.size() <= REQ_LEVEL);
        e_bck = (nn % BCK_DIV) >= BCK_DIV / 2;
        if (fall) begin
          e_lrck = (pos >= SLOT_W);
          e_sout = model_bit(m_frame, pos, m_mode);
        end
        m_n = nn;
      end else begin
        if (acc) exp_q.push_back(wr.in_data);
        m_n = 0; m_base = FRAME_BITS - 1;
        e_bck = 0; e_lrck = 0; e_sout = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge in_clk) begin
    if (model_on) begin
      check("level",     64'(level),       64'(exp_q.size()));
      check("in_ready",  64'(wr.in_ready), 64'(exp_q.size() < DEPTH));
      check("bck",       64'(bck),         64'(e_bck));
      check("lrck",      64'(lrck),        64'(e_lrck));
      check("sout",      64'(sout),        64'(e_sout));
      check("audio_req", 64'(audio_req),   64'(e_req));
      check("underrun",  64'(underrun),    64'(e_und));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    wr.in_valid = 1'b1;
    wr.in_data  = d;
    @(negedge in_clk);
    wr.in_valid = 1'b0;
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = bck;
    ok   = 0;
    for (int i = 0; i < 3 * BCK_DIV && !ok; i++) begin
      @(negedge in_clk);
      if (underrun) und_seen++;
      if (bck && !prev) ok = 1;
      prev = bck;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL bck_rise_timeout: got no rise expected rise at %0t", $time);
    end
  endtask

  // Skips the idle-position rise, then records positions 0..63 MSB-first.
  task automatic capture(output logic [63:0] s_bits, output logic [63:0] l_bits);
    bit ok;
    s_bits   = '0;
    l_bits   = '0;
    und_seen = 0;
    wait_rise(ok);
    for (int i = 0; i < FRAME_BITS; i++) begin
      wait_rise(ok);
      s_bits = {s_bits[62:0], sout};
      l_bits = {l_bits[62:0], lrck};
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] s_bits, l_bits;
    int und_t[3];
    int und_n, req_n, ones, found_k, rate;
    bit ok, found;

    reset = 1'b1; enable = 1'b0; mode = 1'b0;
    wr.in_valid = 1'b0; wr.in_data = '0;
    tick(1);

    // reset held with enable and in_valid active
    enable = 1'b1; wr.in_valid = 1'b1; wr.in_data = 32'hFFFF_FFFF;
    tick(3);
    check("rst_level",    64'(level),       64'd0);
    check("rst_in_ready", 64'(wr.in_ready), 64'd1);
    check("rst_bck",      64'(bck),         64'd0);
    check("rst_lrck",     64'(lrck),        64'd0);
    check("rst_sout",     64'(sout),        64'd0);
    check("rst_req",      64'(audio_req),   64'd0);
    check("rst_underrun", 64'(underrun),    64'd0);
    reset = 1'b0; enable = 1'b0; wr.in_valid = 1'b0;
    tick(2);

    // left-justified frame
    mode = 1'b1;
    push_frame(32'hA5F0_0F5A);
    enable = 1'b1;
    capture(s_bits, l_bits);
    enable = 1'b0;
    check("lj_sout",     s_bits, 64'hA5F0_0000_0F5A_0000);
    check("lj_lrck",     l_bits, 64'h0000_0000_FFFF_FFFF);
    check("lj_underrun", 64'(und_seen), 64'd0);
    tick(2);

    // I2S frame: data one bck behind lrck
    mode = 1'b0;
    push_frame(32'hA5F0_0F5A);
    enable = 1'b1;
    capture(s_bits, l_bits);
    enable = 1'b0;
    check("i2s_sout", s_bits, 64'h52F8_0000_07AD_0000);
    check("i2s_lrck", l_bits, 64'h0000_0000_FFFF_FFFF);
    tick(2);

    // underrun for three frames
    und_n = 0; req_n = 0; ones = 0;
    enable = 1'b1;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      @(negedge in_clk);
      if (underrun) begin
        if (und_n < 3) und_t[und_n] = i;
        und_n++;
      end
      if (audio_req) req_n++;
      if (sout) ones++;
    end
    enable = 1'b0;
    check("und_count", 64'(und_n), 64'd3);
    check("req_count", 64'(req_n), 64'd3);
    check("und_sout",  64'(ones),  64'd0);
    if (und_n >= 3) begin
      check("und_gap1", 64'(und_t[1] - und_t[0]), 64'(FRAME_CYC));
      check("und_gap2", 64'(und_t[2] - und_t[1]), 64'(FRAME_CYC));
    end
    tick(2);

    // fill past full while idle, then drain to the request level
    mode = 1'b1;
    wr.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr.in_data = 32'h1000_0001 * (i + 1);
      @(negedge in_clk);
      if (i == 3) begin
        check("full_ready", 64'(wr.in_ready), 64'd0);
        check("full_level", 64'(level),       64'd4);
      end
    end
    wr.in_valid = 1'b0;
    check("full_drop_level", 64'(level), 64'd4);
    enable = 1'b1;
    found = 0; found_k = 0;
    for (int k = 1; k <= 4 * FRAME_CYC && !found; k++) begin
      @(negedge in_clk);
      if (audio_req) begin
        found   = 1;
        found_k = k;
      end
    end
    check("req_first_cycle", 64'(found_k), 64'(BCK_DIV + 2 * FRAME_CYC));
    check("req_first_level", 64'(level),   64'd1);
    enable = 1'b0;
    reset  = 1'b1;
    tick(1);
    reset  = 1'b0;
    tick(2);

    // abort at bit 20, then the following frame plays from bit 0
    push_frame(32'h1234_5678);
    push_frame(32'hDEAD_BEEF);
    enable = 1'b1;
    wait_rise(ok);
    for (int i = 0; i <= 20; i++) wait_rise(ok);
    check("abort_bck_high", 64'(bck), 64'd1);
    enable = 1'b0;
    @(negedge in_clk);
    check("abort_bck",   64'(bck),   64'd0);
    check("abort_lrck",  64'(lrck),  64'd0);
    check("abort_sout",  64'(sout),  64'd0);
    check("abort_level", 64'(level), 64'd1);
    tick(1);
    enable = 1'b1;
    capture(s_bits, l_bits);
    enable = 1'b0;
    check("resume_sout",  s_bits, 64'hDEAD_0000_BEEF_0000);
    check("resume_level", 64'(level), 64'd0);
    tick(2);

    // randomised traffic against the model
    rate = 0;
    for (int c = 0; c < 12000; c++) begin
      if (c % 512 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 0;
          1: rate = 63;
          2: rate = 300;
          default: rate = 1000;
        endcase
      end
      wr.in_valid = ($urandom_range(0, rate) == 0);
      wr.in_data  = $urandom;
      mode        = $urandom_range(0, 1);
      if ($urandom_range(0, 999) == 0) enable = !enable;
      else if (!enable && $urandom_range(0, 99) == 0) enable = 1'b1;
      reset = ($urandom_range(0, 2999) == 0);
      @(negedge in_clk);
    end
    wr.in_valid = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    tick(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_fifo.md
# i2s_tx_fifo

Parametrised single-clock I2S/left-justified transmitter with an on-chip stereo frame FIFO. Sits between the NeXT sound-out DMA path (in_clk domain) and the external DAC, and generates bck, lrck and sout itself from in_clk through a divider, so no second clock domain or synchronisers are required. Generalises the fixed 32-bit, single-buffer sender: sample width, slot width, FIFO depth and bck ratio are configurable, and it adds a justification mode, level-driven sample requests, underrun reporting and a clean enable/abort.

## Interface
Parameters:
- SAMPLE_W, 16: bits per channel sample; 1..SLOT_W-1.
- SLOT_W, 32: bck periods per channel slot; a frame is 2*SLOT_W bck periods.
- DEPTH, 4: FIFO depth in stereo frames; power of two, at least 2.
- BCK_DIV, 4: in_clk cycles per bck period; even, at least 2.
- REQ_LEVEL, 1: audio_req fires when the post-pop level is at or below this value.

Ports:
- in_clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = run serial output; 0 = idle, FIFO retained.
- mode  in  1  0 = I2S (MSB one bck after the lrck edge); 1 = left-justified. Sampled only at frame start.
- in_valid  in  1  frame write strobe.
- in_data  in  2*SAMPLE_W  {left, right}.
- in_ready  out  1  equals !full.
- level  out  clog2(DEPTH+1)  FIFO occupancy in frames.
- audio_req  out  1  one-cycle request pulse for more samples.
- underrun  out  1  one-cycle pulse when a frame is due but the FIFO is empty.
- bck  out  1  bit clock (registered).
- lrck  out  1  0 = left slot, 1 = right slot (registered).
- sout  out  1  serial data, MSB first (registered).

## Operation
- Reset: bck=0, lrck=0, sout=0, audio_req=0, underrun=0, level=0, FIFO empty, in_ready=1, divider and bit counter cleared, shift register zeroed.
- FIFO: a push occurs when in_valid && in_ready. in_ready depends only on full, so a push is refused when the FIFO is full even if a pop happens in the same cycle. A pop occurs only at frame start. When a push and a pop happen together (FIFO not full), level is unchanged. Read/write pointers wrap modulo DEPTH.
- Divider: counts 0..BCK_DIV-1 while enable=1. bck rises at count BCK_DIV/2 and falls at count 0 (wrap). "Fall cycle" means the in_clk cycle in which the bck register goes 1 to 0.
- Bit counter b runs 0..2*SLOT_W-1 and advances on each fall cycle. On a fall cycle, lrck <= (b_new >= SLOT_W) and sout <= the bit for position b_new.
- Frame start is the fall cycle where b_new = 0:
  - FIFO non-empty: load the head frame into the shift register and pop.
  - FIFO empty: load zeros and pulse underrun.
  - audio_req pulses in the same cycle when the resulting level is at or below REQ_LEVEL.
- Bit placement within a slot at position p (0..SLOT_W-1), with offset d = 0 if mode=1 and d = 1 if mode=0:
  - p in [d, d+SAMPLE_W-1]: sout carries sample bit SAMPLE_W-1-(p-d).
  - Any other p: sout = 0.
- Idle (enable=0): bck, lrck and sout are forced to 0 on the next cycle. Divider is cleared and b is set to 2*SLOT_W-1, so the first fall after enabling is a frame start. Pushes continue normally.
- Enable deasserted mid-frame: the frame is aborted immediately and its remaining bits are discarded, not re-queued.
- Reset mid-operation: returns to reset values next cycle, and FIFO contents are lost.

## Timing
- bck period is BCK_DIV in_clk cycles. A frame is 2*SLOT_W*BCK_DIV cycles (256 with the defaults).
- After enable rises: bck first rises BCK_DIV/2 cycles later, and the first frame start (fall) comes BCK_DIV cycles after enable rises.
- sout and lrck change only on fall cycles, so they are stable across every bck rising edge.
- Write-to-serial latency for an empty FIFO in a running stream: the frame is emitted at the next frame start after the push. A push in the same cycle as a frame start is not visible to that pop.
- audio_req and underrun are each at most one pulse per frame, aligned to the frame-start cycle.

## Test plan
- Reset: hold reset 3 cycles with enable=1 and in_valid=1 → all outputs at reset values, level=0, no push accepted.
- Left-justified, defaults: push {16'hA5F0, 16'h0F5A}, enable → per-frame sout positions 0–15 = A5F0 MSB-first, 16–31 = 0, 32–47 = 0F5A, 48–63 = 0. lrck low for bits 0–31. No underrun on the first frame.
- I2S mode, same frame → every bit is delayed by one bck relative to lrck (position 1 = bit 15 of 16'hA5F0), position 0 of each slot = 0.
- Underrun: enable with an empty FIFO for 3 frames → sout constantly 0, underrun pulses exactly 3 times 256 cycles apart, audio_req pulses each frame.
- Full/req: DEPTH=4, enable=0, push 5 frames back-to-back → in_ready=0 after the 4th push, 5th frame dropped, level=4. Then enable → audio_req first pulses at the frame start where level drops to 1.
- Abort: disable at bit 20 of a frame → bck, lrck and sout go to 0 the next cycle. Re-enable → the next FIFO frame starts at bit 0, and the aborted frame is not replayed.
